muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide ops, placed beside the single-cycle ALU in the execute stage.
- Accepts one operation per start handshake and runs a shift-add/shift-subtract datapath for XLEN iterations.
- Holds the pipeline with stall while it runs, then presents the result with a one-cycle done pulse.
- Decoder drives start and funct when the opcode is OP (7'b0110011) and funct7 is 7'b0000001.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- funct  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand, captured on accept.
- b  in  XLEN  rs2 operand, captured on accept.
- kill  in  1  flush; aborts any in-flight op.
- busy  out  1  high from the cycle after accept until done is deasserted.
- stall  out  1  equals start in IDLE, or busy; holds the pipeline.
- done  out  1  one-cycle pulse; result valid in that cycle.
- result  out  XLEN  op result; holds its value until the next done.

Behaviour:
- Reset (async, rst_n low): state=IDLE, busy=0, done=0, result=0, iteration count=0, operand registers=0.
- Accept: cycle T with state=IDLE, start=1, kill=0. Latch funct, a, b.
  - Signed ops (MULH, MULHSU for a only, DIV, REM): store operand magnitudes and the result sign.
- States:
  - IDLE -> RUN on accept. IDLE -> DONE on accept with a special case.
  - RUN: XLEN cycles (T+1..T+XLEN), one iteration per cycle, count from 0 to XLEN-1.
    - Multiply: 2*XLEN-bit product register, shift-add.
    - Divide: restoring shift-subtract producing quotient and remainder.
  - FIX (T+XLEN+1): apply signs.
    - Select the low half for MUL, the high half for MULH/MULHSU/MULHU.
    - Select the quotient for DIV/DIVU, the remainder for REM/REMU.
    - Register result.
  - DONE (T+XLEN+2): done=1 -> IDLE.
- Normal latency: done at T+XLEN+2 (T+34 for XLEN=32).
- Special cases, detected at accept: state goes IDLE->DONE and done is asserted at T+1.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Signed rules:
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MULHSU treats b as unsigned.
  - All arithmetic is two's complement, XLEN wraps.
- busy: 1 in RUN, FIX and DONE.
- stall: combinational, start&&IDLE || busy. The pipeline releases in the cycle done is high.
- start while busy: ignored, no queueing.
- kill: has priority over every other event.
  - Any state -> IDLE on the next edge, no done pulse, result unchanged.
  - kill and start in the same IDLE cycle: start is not accepted.
- A back-to-back start is accepted in the cycle after done, which is IDLE.
- Reset mid-operation: immediate return to reset values; no done.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 localparams (MD_MUL..MD_REMU).
  - state encoding (S_IDLE, S_RUN, S_FIX, S_DONE).
  - XLEN-derived count width $clog2(XLEN)+1.
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: mode, partial-product/remainder, operand.
  - Outputs: next partial-product/remainder and quotient bit.
  - muldiv_seq owns all registers and the FSM.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start at T -> busy T+1..T+34, done=1 only at T+34, result=0xFFFFFFEB; stall high T..T+34.
- MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE at T+34; MULH with the same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2; each with done at T+34.
- DIVU a=5, b=0 -> done at T+1, result=0xFFFFFFFF; REM a=0x80000000, b=0xFFFFFFFF -> done T+1, result=0; DIV with the same operands -> 0x80000000.
- DIV running, kill=1 at T+10 -> busy=0 at T+11, no done ever, result keeps its prior value; new MUL 3*4 started at T+12 -> done T+46, result=12.
- start held high during RUN with different operands -> ignored, first result correct. rst_n low at T+5 -> busy, done, result = 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module  : muldiv_pkg
// Purpose : Shared funct3 codes, FSM encoding and sizing helpers for muldiv_seq
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

   localparam int MD_XLEN = 32;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // One extra bit so the counter can represent XLEN itself.
   function automatic int cnt_width(input int xlen);
      return $clog2(xlen) + 1;
   endfunction

   localparam int MD_CNT_W = cnt_width(MD_XLEN);

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module  : muldiv_step
// Purpose : One combinational iteration of shift-add multiply / restoring divide
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic                i_div,
   input  logic [2*XLEN-1:0]   i_acc,
   input  logic [XLEN-1:0]     i_opnd,
   output logic [2*XLEN-1:0]   o_acc,
   output logic                o_qbit
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_rem_sh;
   logic [XLEN:0] w_diff;

   // Multiply: acc = {partial product, remaining multiplier}, shifted right.
   // Divide:   acc = {partial remainder, remaining dividend}, shifted left;
   // the quotient bit is returned separately and ORed into bit 0 by the caller.
   always_comb begin
      w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
      w_rem_sh = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
      w_diff   = w_rem_sh - {1'b0, i_opnd};
      o_qbit   = i_div & ~w_diff[XLEN];
      if (i_div) begin
         o_acc = {(w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0]),
                  i_acc[XLEN-2:0], 1'b0};
      end else begin
         o_acc = {w_sum, i_acc[XLEN-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module  : muldiv_seq
// Purpose : Iterative RV32M multiply/divide sequencer with pipeline stall
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        funct,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic              kill,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [XLEN-1:0]   result
);

   localparam int CNT_W = cnt_width(XLEN);
   localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_funct;
   logic [XLEN-1:0]       r_opb;
   logic [2*XLEN-1:0]     r_acc;
   logic                  r_neg;
   logic [CNT_W-1:0]      r_cnt;
   logic [XLEN-1:0]       r_result;

   logic                  w_accept;
   logic                  w_sgn_a;
   logic                  w_sgn_b;
   logic [XLEN-1:0]       w_mag_a;
   logic [XLEN-1:0]       w_mag_b;
   logic                  w_neg;
   logic                  w_div0;
   logic                  w_ovf;
   logic                  w_special;
   logic [XLEN-1:0]       w_spec_res;
   logic                  w_last;
   logic [2*XLEN-1:0]     w_step_acc;
   logic                  w_qbit;
   logic [2*XLEN-1:0]     w_prod;
   logic [XLEN-1:0]       w_quo;
   logic [XLEN-1:0]       w_rem;
   logic [XLEN-1:0]       w_fix_res;

   // ---------------------------------------------------------------- accept
   always_comb begin
      w_accept   = (r_state == S_IDLE) && start && !kill;
      w_sgn_a    = a[XLEN-1] && (funct == MD_MULH || funct == MD_MULHSU ||
                                 funct == MD_DIV  || funct == MD_REM);
      w_sgn_b    = b[XLEN-1] && (funct == MD_MULH || funct == MD_DIV || funct == MD_REM);
      w_mag_a    = w_sgn_a ? (~a + 1'b1) : a;
      w_mag_b    = w_sgn_b ? (~b + 1'b1) : b;
      // Remainder follows the dividend; everything else is the sign product.
      w_neg      = (funct == MD_REM) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
      w_div0     = funct[2] && (b == '0);
      w_ovf      = (funct == MD_DIV || funct == MD_REM) && (a == C_MIN_NEG) && (b == '1);
      w_special  = w_div0 || w_ovf;
      w_spec_res = '0;
      if (w_div0) begin
         w_spec_res = funct[1] ? a : '1;
      end else if (w_ovf) begin
         w_spec_res = funct[1] ? '0 : C_MIN_NEG;
      end
   end

   // ---------------------------------------------------------------- iterate
   muldiv_step #(.XLEN(XLEN)) u_step (
      .i_div  (r_funct[2]),
      .i_acc  (r_acc),
      .i_opnd (r_opb),
      .o_acc  (w_step_acc),
      .o_qbit (w_qbit)
   );

   // ---------------------------------------------------------------- sign fix
   always_comb begin
      w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
      w_quo  = r_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
      w_rem  = r_neg ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
      case (r_funct)
         MD_MUL:                    w_fix_res = w_prod[XLEN-1:0];
         MD_MULH, MD_MULHSU,
         MD_MULHU:                  w_fix_res = w_prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:           w_fix_res = w_quo;
         default:                   w_fix_res = w_rem;
      endcase
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last      = (r_cnt == CNT_W'(XLEN - 1));
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = w_special ? S_DONE : S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (kill) w_state_nxt = S_IDLE;
      busy   = (r_state != S_IDLE);
      done   = (r_state == S_DONE);
      stall  = ((r_state == S_IDLE) && start) || busy;
      result = r_result;
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_funct  <= '0;
         r_opb    <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_funct <= funct;
         r_opb   <= w_mag_b;
         r_acc   <= {{XLEN{1'b0}}, w_mag_a};
         r_neg   <= w_neg;
         r_cnt   <= '0;
         if (w_special) r_result <= w_spec_res;
      end else if (r_state == S_RUN) begin
         r_acc <= w_step_acc | {{(2*XLEN-1){1'b0}}, w_qbit};
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIX && !kill) begin
         r_result <= w_fix_res;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module  : tb_muldiv_seq
// Purpose : Self-checking bench for muldiv_seq against an arithmetic model
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

   localparam int XLEN = 32;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [2:0]        funct;
   logic [XLEN-1:0]   a;
   logic [XLEN-1:0]   b;
   logic              kill;
   logic              busy;
   logic              stall;
   logic              done;
   logic [XLEN-1:0]   result;

   int                n_chk = 0;
   int                n_err = 0;
   logic [XLEN-1:0]   last_res;

   muldiv_seq #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct  (funct),
      .a      (a),
      .b      (b),
      .kill   (kill),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      if (f[2] && y == 32'd0) return 1'b1;
      if ((f == 3'b100 || f == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint      sx;
      longint      sy;
      logic [63:0] ux;
      logic [63:0] uy;
      logic [63:0] p;
      int          q;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (f)
         3'b000: begin p = ux * uy;             return p[31:0];  end
         3'b001: begin p = 64'(sx * sy);        return p[63:32]; end
         3'b010: begin p = 64'(sx * longint'(uy)); return p[63:32]; end
         3'b011: begin p = ux * uy;             return p[63:32]; end
         3'b100: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = $signed(x) / $signed(y);
            return q;
         end
         3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'b110: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            q = $signed(x) % $signed(y);
            return q;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Issue one op; optionally keep start high with junk operands while busy.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input bit hold);
      logic [31:0] exp_res;
      int          exp_lat;
      int          lat;
      int          busy_gaps;
      logic [31:0] got;
      exp_res   = model(f, av, bv);
      exp_lat   = is_special(f, av, bv) ? 1 : XLEN + 2;
      lat       = 0;
      busy_gaps = 0;
      got       = 'x;
      @(negedge clk);
      start = 1'b1; funct = f; a = av; b = bv;
      #1 check({tag, "_stall_T"}, stall, 1);
      @(posedge clk);
      #1;
      if (hold) begin
         a = $urandom; b = $urandom; funct = 3'($urandom_range(0, 7));
      end else begin
         start = 1'b0;
      end
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (!busy || !stall) busy_gaps++;
         if (done) begin
            lat = k;
            got = result;
            break;
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, got, exp_res);
      check({tag, "_busy_run"}, busy_gaps, 0);
      @(negedge clk);
      check({tag, "_idle_after"}, {busy, done}, 2'b00);
      check({tag, "_hold"}, result, exp_res);
      last_res = exp_res;
   endtask

   initial begin
      int dones;
      rst_n = 1'b0; start = 1'b0; funct = '0; a = '0; b = '0; kill = 1'b0;
      last_res = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_stall", stall, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed operations
      run_op("mul_neg",    3'b000, 32'd7,          32'hFFFF_FFFD, 1'b0);
      run_op("mulhu_ff",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
      run_op("mulh_ff",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
      run_op("mulhsu_ff",  3'b010, 32'hFFFF_FFFF,  32'd2,         1'b0);
      run_op("div_neg",    3'b100, 32'hFFFF_FFF9,  32'd2,         1'b0);
      run_op("rem_neg",    3'b110, 32'hFFFF_FFF9,  32'd2,         1'b0);
      run_op("divu",       3'b101, 32'd100,        32'd7,         1'b0);
      run_op("remu",       3'b111, 32'd100,        32'd7,         1'b0);
      run_op("divu_zero",  3'b101, 32'd5,          32'd0,         1'b0);
      run_op("rem_zero",   3'b110, 32'd5,          32'd0,         1'b0);
      run_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
      run_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
      run_op("mul_hold",   3'b000, 32'd1234,       32'd5678,      1'b1);

      // Kill at T+10 during a divide, then a fresh MUL at T+12
      @(negedge clk);
      start = 1'b1; funct = 3'b100; a = 32'd1000; b = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      dones = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      if (done) dones++;
      check("kill_busy", busy, 0);
      check("kill_nodone", dones, 0);
      check("kill_result", result, last_res);
      run_op("mul_after_kill", 3'b000, 32'd3, 32'd4, 1'b0);

      // Kill and start together in IDLE: not accepted
      @(negedge clk);
      start = 1'b1; kill = 1'b1; funct = 3'b000; a = 32'd9; b = 32'd9;
      @(posedge clk);
      #1 start = 1'b0; kill = 1'b0;
      @(negedge clk);
      check("kill_start_busy", busy, 0);

      // Asynchronous reset mid-operation
      @(negedge clk);
      start = 1'b1; funct = 3'b011; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("arst_nodone", dones, 0);
      last_res = '0;

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  rf;
         logic [31:0] ra;
         logic [31:0] rb;
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op("rand", rf, ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
